// File: rtl/wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : wb_sequencer
// Purpose : Multicycle writeback controller driving the register-file
//           write-data select, destination address and write enable.
// Revision: 1.0 - initial release
// ============================================================================
module wb_sequencer #(
    parameter int SP_REG     = 29,
    parameter int INIT_SP_EN = 1,
    parameter int MD_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [3:0] wb_kind,
    input  logic [4:0] wb_dst_a,
    input  logic [4:0] wb_dst_b,
    input  logic       muldiv_done,
    output logic       req_ready,
    output logic [3:0] reg_data_sel,
    output logic [4:0] reg_dst,
    output logic       reg_write,
    output logic       xchg_load,
    output logic       wb_done,
    output logic       wb_err
);

    localparam logic [4:0] C_SP_REG    = 5'(SP_REG);
    localparam logic [8:0] C_MD_LIMIT  = 9'(MD_TIMEOUT);
    localparam logic [3:0] C_SEL_INIT  = 4'b0110;
    localparam logic [3:0] C_SEL_REGA  = 4'b1000;
    localparam logic [3:0] C_SEL_XCHG  = 4'b0111;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_INIT_SP  = 4'd1,
        S_IDLE     = 4'd2,
        S_WAIT_MD  = 4'd3,
        S_WRITE    = 4'd4,
        S_XCHG_CAP = 4'd5,
        S_XCHG_W1  = 4'd6,
        S_XCHG_W2  = 4'd7,
        S_ERR      = 4'd8
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] kind_q,  kind_d;
    logic [4:0] dst_a_q, dst_a_d;
    logic [4:0] dst_b_q, dst_b_d;
    logic [7:0] cnt_q,   cnt_d;

    logic       ready_q, ready_d;
    logic [3:0] sel_q,   sel_d;
    logic [4:0] dst_q,   dst_d;
    logic       we_q,    we_d;
    logic       load_q,  load_d;
    logic       done_q,  done_d;
    logic       err_q,   err_d;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        dst_a_d = dst_a_q;
        dst_b_d = dst_b_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RST:     state_d = (INIT_SP_EN != 0) ? S_INIT_SP : S_IDLE;
            S_INIT_SP: state_d = S_IDLE;
            S_IDLE: begin
                if (wb_req) begin
                    kind_d  = wb_kind;
                    dst_a_d = wb_dst_a;
                    dst_b_d = wb_dst_b;
                    if (wb_kind == 4'b0001)
                        state_d = S_WAIT_MD;
                    else if (wb_kind == 4'b0111)
                        state_d = S_XCHG_CAP;
                    else if (wb_kind == 4'b0110 || wb_kind >= 4'b1010)
                        state_d = S_ERR;
                    else
                        state_d = S_WRITE;
                end
            end
            S_WAIT_MD: begin
                // Completion is checked first so it wins over a coincident timeout.
                if (muldiv_done) begin
                    state_d = S_WRITE;
                    cnt_d   = 8'd0;
                end else if (({1'b0, cnt_q} + 9'd1) == C_MD_LIMIT) begin
                    state_d = S_ERR;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            S_WRITE:    state_d = S_IDLE;
            S_XCHG_CAP: state_d = S_XCHG_W1;
            S_XCHG_W1:  state_d = S_XCHG_W2;
            S_XCHG_W2:  state_d = S_IDLE;
            S_ERR:      state_d = S_IDLE;
            default:    state_d = S_RST;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        ready_d = 1'b0;
        sel_d   = 4'd0;
        dst_d   = 5'd0;
        we_d    = 1'b0;
        load_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_d)
            S_INIT_SP: begin
                sel_d = C_SEL_INIT;
                dst_d = C_SP_REG;
                we_d  = (C_SP_REG != 5'd0);
            end
            S_IDLE:     ready_d = 1'b1;
            S_WRITE: begin
                sel_d  = kind_d;
                dst_d  = dst_a_d;
                we_d   = (dst_a_d != 5'd0);
                done_d = 1'b1;
            end
            S_XCHG_CAP: load_d = 1'b1;
            S_XCHG_W1: begin
                sel_d = C_SEL_REGA;
                dst_d = dst_a_d;
                we_d  = (dst_a_d != 5'd0);
            end
            S_XCHG_W2: begin
                sel_d  = C_SEL_XCHG;
                dst_d  = dst_b_d;
                we_d   = (dst_b_d != 5'd0);
                done_d = 1'b1;
            end
            S_ERR:      err_d = 1'b1;
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RST;
            kind_q  <= 4'd0;
            dst_a_q <= 5'd0;
            dst_b_q <= 5'd0;
            cnt_q   <= 8'd0;
            ready_q <= 1'b0;
            sel_q   <= 4'd0;
            dst_q   <= 5'd0;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            dst_a_q <= dst_a_d;
            dst_b_q <= dst_b_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            sel_q   <= sel_d;
            dst_q   <= dst_d;
            we_q    <= we_d;
            load_q  <= load_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready    = ready_q;
    assign reg_data_sel = sel_q;
    assign reg_dst      = dst_q;
    assign reg_write    = we_q;
    assign xchg_load    = load_q;
    assign wb_done      = done_q;
    assign wb_err       = err_q;

endmodule
`default_nettype wire
